// File: rtl/score_display_ctrl_pkg.sv
// Shared constants, conversion FSM states and the BCD add-3 helper
// for the score display controller.
package score_display_ctrl_pkg;

    localparam int         NUM_DIGITS     = 4;
    localparam logic [3:0] SEG_BLANK_CODE = 4'hF;
    localparam logic [13:0] MAX_SCORE     = 14'd9999;
    localparam logic [3:0] LAST_BIT       = 4'd13;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        DONE = 2'd2
    } conv_state_t;

    // One double-dabble correction step: every nibble >= 5 gets +3.
    function automatic logic [15:0] add3_bcd(input logic [15:0] bcd);
        logic [15:0] res;
        res = bcd;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (bcd[i*4 +: 4] >= 4'd5)
                res[i*4 +: 4] = bcd[i*4 +: 4] + 4'd3;
        end
        return res;
    endfunction

endpackage

// File: rtl/score_display_ctrl_seg_decoder.sv
// BCD digit to active-low seven-segment pattern (gfedcba).
// Codes 10..15 decode to all segments off; 4'hF is the blanking code.
module seg_decoder (
    input  logic [3:0] digit,
    output logic [6:0] seg
);

    always_comb begin
        seg = 7'b1111111;
        case (digit)
            4'd0: seg = 7'b1000000;
            4'd1: seg = 7'b1111001;
            4'd2: seg = 7'b0100100;
            4'd3: seg = 7'b0110000;
            4'd4: seg = 7'b0011001;
            4'd5: seg = 7'b0010010;
            4'd6: seg = 7'b0000010;
            4'd7: seg = 7'b1111000;
            4'd8: seg = 7'b0000000;
            4'd9: seg = 7'b0010000;
            default: seg = 7'b1111111;
        endcase
    end

endmodule

// File: rtl/score_display_ctrl.sv
// Score display controller: sequential binary-to-BCD conversion plus a
// free-running 4-digit multiplexed scan through one shared seg_decoder.
module score_display_ctrl
    import score_display_ctrl_pkg::*;
#(
    parameter int REFRESH_DIV = 50000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [13:0] score,
    input  logic        score_valid,
    input  logic        blank_lz,
    output logic        busy,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dp
);

    localparam int CNT_W = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(REFRESH_DIV - 1);

    conv_state_t      state;
    logic [3:0]       bit_cnt;
    logic [29:0]      shift_reg;
    logic [29:0]      shift_corr;
    logic [15:0]      disp_digits;
    logic [13:0]      score_sat;

    logic [CNT_W-1:0] refresh_cnt;
    logic [1:0]       digit_idx;
    logic [3:0]       nibble;
    logic [3:0]       dec_in;
    logic [6:0]       seg_next;

    assign score_sat  = (score > MAX_SCORE) ? MAX_SCORE : score;
    assign shift_corr = {add3_bcd(shift_reg[29:14]), shift_reg[13:0]};

    // disp_digits is written only in DONE so the scan never sees a partial result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            busy        <= 1'b0;
            bit_cnt     <= 4'd0;
            shift_reg   <= 30'd0;
            disp_digits <= 16'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (score_valid) begin
                        shift_reg <= {16'd0, score_sat};
                        bit_cnt   <= LAST_BIT;
                        state     <= CONV;
                        busy      <= 1'b1;
                    end
                end
                CONV: begin
                    shift_reg <= {shift_corr[28:0], 1'b0};
                    if (bit_cnt == 4'd0)
                        state <= DONE;
                    else
                        bit_cnt <= bit_cnt - 4'd1;
                end
                DONE: begin
                    disp_digits <= shift_reg[29:14];
                    state       <= IDLE;
                    busy        <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            refresh_cnt <= '0;
            digit_idx   <= 2'd0;
        end else if (refresh_cnt == CNT_MAX) begin
            refresh_cnt <= '0;
            digit_idx   <= digit_idx + 2'd1;
        end else begin
            refresh_cnt <= refresh_cnt + 1'b1;
        end
    end

    // A digit is blanked only when it and every more significant digit are zero.
    always_comb begin
        nibble = disp_digits[digit_idx*4 +: 4];
        dec_in = nibble;
        if (blank_lz) begin
            case (digit_idx)
                2'd3: if (disp_digits[15:12] == 4'd0) dec_in = SEG_BLANK_CODE;
                2'd2: if (disp_digits[15:8]  == 8'd0) dec_in = SEG_BLANK_CODE;
                2'd1: if (disp_digits[15:4]  == 12'd0) dec_in = SEG_BLANK_CODE;
                default: dec_in = nibble;
            endcase
        end
    end

    seg_decoder u_seg_decoder (
        .digit (dec_in),
        .seg   (seg_next)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            an  <= 4'b1111;
            seg <= 7'b1111111;
        end else begin
            an  <= ~(4'b0001 << digit_idx);
            seg <= seg_next;
        end
    end

    assign dp = 1'b1;

endmodule

// File: tb/tb_score_display_ctrl.sv
// Directed bench for score_display_ctrl with REFRESH_DIV=4: a vector table
// of score/blanking cases plus hand sequences for reset and busy behaviour.
module tb_score_display_ctrl;

    localparam logic [6:0] S_OFF = 7'b1111111;
    localparam logic [6:0] S_0   = 7'b1000000;
    localparam logic [6:0] S_1   = 7'b1111001;
    localparam logic [6:0] S_2   = 7'b0100100;
    localparam logic [6:0] S_3   = 7'b0110000;
    localparam logic [6:0] S_4   = 7'b0011001;
    localparam logic [6:0] S_5   = 7'b0010010;
    localparam logic [6:0] S_7   = 7'b1111000;
    localparam logic [6:0] S_8   = 7'b0000000;
    localparam logic [6:0] S_9   = 7'b0010000;

    logic        clk = 1'b0;
    logic        rst;
    logic [13:0] score;
    logic        score_valid;
    logic        blank_lz;
    logic        busy;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;

    int checks = 0;
    int errors = 0;

    logic [6:0] got [4];
    logic       seen [4];
    logic       five_seen;

    typedef struct {
        logic [13:0] score;
        logic        blank;
        logic [6:0]  exp [4];
    } vec_t;

    vec_t vecs [8];

    score_display_ctrl #(.REFRESH_DIV(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .score       (score),
        .score_valid (score_valid),
        .blank_lz    (blank_lz),
        .busy        (busy),
        .an          (an),
        .seg         (seg),
        .dp          (dp)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Starts at a negedge; edge N is the next posedge. Returns at the negedge after N.
    task automatic load(input logic [13:0] s);
        score       = s;
        score_valid = 1'b1;
        @(negedge clk);
        score_valid = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (busy === 1'b1 && n < 40) begin
            n++;
            @(negedge clk);
        end
        check({name, "_idle"}, {31'd0, busy}, 32'd0);
    endtask

    // Records the last segment pattern seen for each anode over a full frame plus margin.
    task automatic capture(input string name);
        for (int d = 0; d < 4; d++) begin
            got[d]  = 7'bx;
            seen[d] = 1'b0;
        end
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (seg === S_5) five_seen = 1'b1;
            case (an)
                4'b1110: begin got[0] = seg; seen[0] = 1'b1; end
                4'b1101: begin got[1] = seg; seen[1] = 1'b1; end
                4'b1011: begin got[2] = seg; seen[2] = 1'b1; end
                4'b0111: begin got[3] = seg; seen[3] = 1'b1; end
                default: check({name, "_an_onehot"}, {28'd0, an}, 32'hE);
            endcase
        end
        check({name, "_all_digits_seen"}, {28'd0, seen[3], seen[2], seen[1], seen[0]}, 32'hF);
    endtask

    task automatic check_frame(input string name, input logic [6:0] e0, input logic [6:0] e1,
                               input logic [6:0] e2, input logic [6:0] e3);
        capture(name);
        check({name, "_d0"}, {25'd0, got[0]}, {25'd0, e0});
        check({name, "_d1"}, {25'd0, got[1]}, {25'd0, e1});
        check({name, "_d2"}, {25'd0, got[2]}, {25'd0, e2});
        check({name, "_d3"}, {25'd0, got[3]}, {25'd0, e3});
    endtask

    initial begin
        int n;

        vecs[0] = '{score: 14'd1234,  blank: 1'b0, exp: '{S_4, S_3, S_2, S_1}};
        vecs[1] = '{score: 14'd12000, blank: 1'b0, exp: '{S_9, S_9, S_9, S_9}};
        vecs[2] = '{score: 14'd7,     blank: 1'b1, exp: '{S_7, S_OFF, S_OFF, S_OFF}};
        vecs[3] = '{score: 14'd0,     blank: 1'b1, exp: '{S_0, S_OFF, S_OFF, S_OFF}};
        vecs[4] = '{score: 14'd1005,  blank: 1'b1, exp: '{S_5, S_0, S_0, S_1}};
        vecs[5] = '{score: 14'd40,    blank: 1'b1, exp: '{S_0, S_4, S_OFF, S_OFF}};
        vecs[6] = '{score: 14'd9999,  blank: 1'b0, exp: '{S_9, S_9, S_9, S_9}};
        vecs[7] = '{score: 14'd10000, blank: 1'b1, exp: '{S_9, S_9, S_9, S_9}};

        rst         = 1'b1;
        score       = '0;
        score_valid = 1'b0;
        blank_lz    = 1'b0;
        five_seen   = 1'b0;
        #23;
        check("reset_an",   {28'd0, an},   32'hF);
        check("reset_seg",  {25'd0, seg},  {25'd0, S_OFF});
        check("reset_dp",   {31'd0, dp},   32'd1);
        check("reset_busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("first_an_after_reset", {28'd0, an}, 32'hE);
        check_frame("post_reset_noblank", S_0, S_0, S_0, S_0);
        blank_lz = 1'b1;
        check_frame("post_reset_blank", S_0, S_OFF, S_OFF, S_OFF);

        // Mid-frame async reset with a non-zero display.
        blank_lz = 1'b0;
        @(negedge clk);
        load(14'd1234);
        wait_idle("pre_reset_load");
        repeat (6) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("midframe_reset_an",   {28'd0, an},   32'hF);
        check("midframe_reset_seg",  {25'd0, seg},  {25'd0, S_OFF});
        check("midframe_reset_busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        check_frame("after_midframe_reset", S_0, S_0, S_0, S_0);

        // Busy width on a single load.
        load(14'd1234);
        n = 0;
        while (busy === 1'b1 && n < 40) begin
            n++;
            @(negedge clk);
        end
        check("busy_cycles", n, 32'd15);

        for (int i = 0; i < 8; i++) begin
            blank_lz = vecs[i].blank;
            load(vecs[i].score);
            wait_idle($sformatf("vec%0d", i));
            @(negedge clk);
            check_frame($sformatf("vec%0d_%0d", i, vecs[i].score),
                        vecs[i].exp[0], vecs[i].exp[1], vecs[i].exp[2], vecs[i].exp[3]);
        end

        // blank_lz takes effect without reloading (display still holds 10000 -> 9999 from vec7).
        blank_lz = 1'b0;
        load(14'd7);
        wait_idle("blank_toggle");
        @(negedge clk);
        check_frame("seven_noblank", S_7, S_0, S_0, S_0);
        blank_lz = 1'b1;
        @(negedge clk);
        check_frame("seven_blank_again", S_7, S_OFF, S_OFF, S_OFF);

        // A strobe while busy is dropped.
        blank_lz = 1'b0;
        load(14'd42);
        repeat (3) @(negedge clk);
        score       = 14'd99;
        score_valid = 1'b1;
        @(negedge clk);
        score_valid = 1'b0;
        wait_idle("busy_drop");
        repeat (3) @(negedge clk);
        check("busy_drop_not_queued", {31'd0, busy}, 32'd0);
        check_frame("busy_drop", S_2, S_4, S_0, S_0);

        // Reset during conversion abandons it; no 5 must ever reach the display.
        five_seen = 1'b0;
        load(14'd5555);
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("reset_conv_busy", {31'd0, busy}, 32'd0);
        rst = 1'b0;
        check_frame("reset_conv_zero", S_0, S_0, S_0, S_0);
        load(14'd8);
        wait_idle("reset_conv_load8");
        @(negedge clk);
        check_frame("reset_conv_eight", S_8, S_0, S_0, S_0);
        check("no_five_visible", {31'd0, five_seen}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
